reaction_timer_bcd: RTL and testbench

//  Multi-channel reaction timer with a BCD count and a parametrised number of digits.
//  A start pulse clears the count and arms every channel. The count then advances once per

---
 rtl/reaction_pkg.sv | 40 ++++
 rtl/reaction_timer_bcd_if.sv | 36 +++
 rtl/bcd_incr.sv | 30 +++
 rtl/reaction_timer_bcd.sv | 183 ++++++++++++++++++
 tb/tb_reaction_timer_bcd.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reaction_pkg.sv
// Shared types and helpers for the BCD reaction timer.
// Holds state encoding, digit width and BCD utility functions.
package reaction_pkg;

    localparam int BCD_W = 4;
    localparam int MAX_W = 64;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Low 'digits' nibbles set to 9; caller keeps the width it needs.
    function automatic logic [MAX_W-1:0] bcd_all_nines(input int digits);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W / BCD_W; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = 4'd9;
            end
        end
        return r;
    endfunction

    // Compare digit by digit from the most significant end.
    function automatic logic bcd_lt(input logic [MAX_W-1:0] a,
                                    input logic [MAX_W-1:0] b);
        logic res;
        logic decided;
        res = 1'b0;
        decided = 1'b0;
        for (int i = MAX_W / BCD_W - 1; i >= 0; i--) begin
            if (!decided && a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W]) begin
                res = a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W];
                decided = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reaction_timer_bcd_if.sv
// Handshake/bus bundle of the reaction timer.
// master: start/stop driver; slave: the timer (count, lat, done, busy, ...).
interface reaction_timer_bcd_if
    import reaction_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CHANNELS = 2
);
    localparam int W  = BCD_W * DIGITS;
    localparam int WW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                  start;
    logic [CHANNELS-1:0]   stop;
    logic [W-1:0]          count;
    logic [W*CHANNELS-1:0] lat;
    logic [CHANNELS-1:0]   done;
    logic                  busy;
    logic                  out_time;
    logic [WW-1:0]         winner;
    logic                  winner_valid;
    logic [W-1:0]          best;
    logic                  best_valid;

    modport master (
        output start, stop,
        input  count, lat, done, busy, out_time,
        input  winner, winner_valid, best, best_valid
    );

    modport slave (
        input  start, stop,
        output count, lat, done, busy, out_time,
        output winner, winner_valid, best, best_valid
    );

endinterface

// File: rtl/bcd_incr.sv
// Combinational multi-digit BCD +1 with carry-out.
// a_i: BCD input, y_o: a_i+1 (wraps), co_o: a_i was all 9s.
module bcd_incr
    import reaction_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [BCD_W*DIGITS-1:0] a_i,
    output logic [BCD_W*DIGITS-1:0] y_o,
    output logic                    co_o
);
    logic c;

    always_comb begin
        c   = 1'b1;
        y_o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (c && a_i[i*BCD_W +: BCD_W] == 4'd9) begin
                y_o[i*BCD_W +: BCD_W] = 4'd0;
            end else if (c) begin
                y_o[i*BCD_W +: BCD_W] = a_i[i*BCD_W +: BCD_W] + 4'd1;
                c = 1'b0;
            end else begin
                y_o[i*BCD_W +: BCD_W] = a_i[i*BCD_W +: BCD_W];
            end
        end
        co_o = c;
    end

endmodule

// File: rtl/reaction_timer_bcd.sv
// Multi-channel BCD reaction timer with winner, timeout and best time.
// Ports: clk, rst (async high), bus (slave modport: start/stop in, results out).
module reaction_timer_bcd
    import reaction_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int CHANNELS = 2,
    parameter int TICK_DIV = 50000
) (
    input logic              clk,
    input logic              rst,
    reaction_timer_bcd_if.slave bus
);
    localparam int W  = BCD_W * DIGITS;
    localparam int WW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [MAX_W-1:0] ALL9_WIDE = bcd_all_nines(DIGITS);
    localparam logic [W-1:0]     ALL9      = ALL9_WIDE[W-1:0];
    localparam logic [PW-1:0]    PSC_LAST  = PW'(TICK_DIV - 1);

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         psc_q, psc_d;
    logic [W-1:0]          count_q, count_d;
    logic [CHANNELS-1:0]   stop_q;
    logic                  out_q, out_d;
    logic [WW-1:0]         win_q, win_d;
    logic                  wv_q, wv_d;
    logic [W-1:0]          best_q, best_d;
    logic                  bv_q, bv_d;

    logic                  run, tick, sat, fin;
    logic [CHANNELS-1:0]   acc;
    logic [W-1:0]          inc;
    logic                  inc_co;
    logic [W*CHANNELS-1:0] lat_nx, lat_cur;
    logic [CHANNELS-1:0]   done_nx, done_cur;
    logic [W-1:0]          win_lat;

    bcd_incr #(.DIGITS(DIGITS)) u_incr (
        .a_i  (count_q),
        .y_o  (inc),
        .co_o (inc_co)
    );

    assign run  = (state_q == ST_RUN);
    assign tick = run && (psc_q == PSC_LAST);
    // Carry out of the incrementer means the count is already all 9s.
    assign sat  = tick && inc_co;
    assign acc  = {CHANNELS{run && !bus.start}}
                & bus.stop & ~stop_q & ~done_cur;
    assign fin  = run && !bus.start && ((&done_nx) || sat);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [W-1:0] lat_q, lat_d;
        logic         done_q, done_d;

        always_comb begin
            lat_d  = lat_q;
            done_d = done_q;
            if (bus.start) begin
                lat_d  = '0;
                done_d = 1'b0;
            end else if (acc[c]) begin
                lat_d  = count_q;
                done_d = 1'b1;
            end else if (sat && !done_q) begin
                lat_d  = ALL9;
                done_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lat_q  <= '0;
                done_q <= 1'b0;
            end else begin
                lat_q  <= lat_d;
                done_q <= done_d;
            end
        end

        assign lat_nx[c*W +: W]  = lat_d;
        assign lat_cur[c*W +: W] = lat_q;
        assign done_nx[c]        = done_d;
        assign done_cur[c]       = done_q;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = ST_RUN;
        end else if (fin) begin
            state_d = ST_DONE;
        end
    end

    // FSM: outputs
    always_comb begin
        bus.busy = (state_q == ST_RUN);
    end

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        if (bus.start) begin
            count_d = '0;
            psc_d   = '0;
        end else if (run) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
            if (tick && !sat) begin
                count_d = inc;
            end
        end
    end

    // Winner priority encoder and best-time tracking.
    always_comb begin
        win_d  = win_q;
        wv_d   = wv_q;
        out_d  = out_q;
        best_d = best_q;
        bv_d   = bv_q;
        if (bus.start) begin
            win_d = '0;
            wv_d  = 1'b0;
            out_d = 1'b0;
        end else begin
            if (!wv_q && (|acc)) begin
                wv_d = 1'b1;
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (acc[i]) begin
                        win_d = WW'(i);
                    end
                end
            end
            if (sat) begin
                out_d = 1'b1;
            end
        end
        win_lat = lat_nx[int'(win_d)*W +: W];
        if (fin && wv_d && !out_d) begin
            if (!bv_q || bcd_lt(MAX_W'(win_lat), MAX_W'(best_q))) begin
                best_d = win_lat;
            end
            bv_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            psc_q   <= '0;
            count_q <= '0;
            stop_q  <= '0;
            out_q   <= 1'b0;
            win_q   <= '0;
            wv_q    <= 1'b0;
            best_q  <= '0;
            bv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            count_q <= count_d;
            stop_q  <= bus.stop;
            out_q   <= out_d;
            win_q   <= win_d;
            wv_q    <= wv_d;
            best_q  <= best_d;
            bv_q    <= bv_d;
        end
    end

    assign bus.count        = count_q;
    assign bus.lat          = lat_cur;
    assign bus.done         = done_cur;
    assign bus.out_time     = out_q;
    assign bus.winner       = win_q;
    assign bus.winner_valid = wv_q;
    assign bus.best         = best_q;
    assign bus.best_valid   = bv_q;

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Self-checking bench for reaction_timer_bcd (4 digits, 2 channels, div 4).
// Reference model tracks elapsed run cycles as an integer.
module tb_reaction_timer_bcd;

    localparam int DIG = 4;
    localparam int CH  = 2;
    localparam int TD  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reaction_timer_bcd_if #(.DIGITS(DIG), .CHANNELS(CH)) bus ();

    reaction_timer_bcd #(
        .DIGITS   (DIG),
        .CHANNELS (CH),
        .TICK_DIV (TD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit         m_run;
    int         m_n;
    int         m_lat [2];
    logic [1:0] m_done;
    bit         m_out;
    bit         m_wv;
    int         m_win;
    int         m_best;
    bit         m_bv;
    logic [1:0] m_prev;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function int m_count();
        return (m_n / TD > 9999) ? 9999 : m_n / TD;
    endfunction

    task automatic model_clear(input bit keep_best);
        m_run = 0; m_n = 0;
        m_lat[0] = 0; m_lat[1] = 0;
        m_done = 2'b00; m_out = 0; m_wv = 0; m_win = 0;
        if (!keep_best) begin
            m_best = 0; m_bv = 0; m_prev = 2'b00;
        end
    endtask

    task automatic cyc(input logic st, input logic [1:0] sp);
        logic [1:0] acc;
        int cur;
        bus.start = st;
        bus.stop  = sp;
        @(posedge clk);
        if (st) begin
            model_clear(1);
            m_run = 1;
        end else if (m_run) begin
            acc = sp & ~m_prev & ~m_done;
            cur = m_count();
            for (int c = 0; c < 2; c++) begin
                if (acc[c]) begin
                    m_lat[c] = cur;
                    m_done[c] = 1'b1;
                end
            end
            if (!m_wv && acc != 2'b00) begin
                m_wv = 1;
                m_win = acc[0] ? 0 : 1;
            end
            if (m_n + 1 == 10000 * TD) begin
                for (int c = 0; c < 2; c++)
                    if (!m_done[c]) m_lat[c] = 9999;
                m_done = 2'b11;
                m_out = 1;
            end
            m_n++;
            if (m_done == 2'b11) begin
                m_run = 0;
                if (m_wv && !m_out) begin
                    if (!m_bv || m_lat[m_win] < m_best)
                        m_best = m_lat[m_win];
                    m_bv = 1;
                end
            end
        end
        m_prev = sp;
        #1;
    endtask

    task automatic run_until(input int n, input logic [1:0] sp);
        int guard;
        guard = 0;
        while (m_n < n && guard < 50000) begin
            cyc(1'b0, sp);
            guard++;
        end
    endtask

    task automatic test_reset();
        logic [70:0] all;
        bus.start = 1'b0;
        bus.stop  = 2'b00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear(0);
        cyc(1'b0, 2'b11);
        cyc(1'b0, 2'b00);
        checks++;
        if (bus.done !== 2'b00 || bus.lat !== 32'h0) begin
            errors++;
            $display("FAIL idle_stop got done=%b lat=%h exp 00/0",
                     bus.done, bus.lat);
        end
        cyc(1'b1, 2'b00);
        run_until(20, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_clear(0);
        all = {bus.count, bus.lat, bus.done, bus.busy, bus.out_time,
               bus.winner, bus.winner_valid, bus.best, bus.best_valid};
        checks++;
        if (all !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", all);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 2'b00);
        checks++;
        if (bus.busy !== 1'b1 || bus.count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_start got busy=%b count=%h exp 1/0000",
                     bus.busy, bus.count);
        end
    endtask

    task automatic test_basic();
        cyc(1'b1, 2'b00);
        run_until(148, 2'b00);
        cyc(1'b0, 2'b10);
        cyc(1'b0, 2'b00);
        checks++;
        if (bus.lat[31:16] !== 16'h0037 || bus.done !== 2'b10 ||
            bus.winner !== 1'b1 || bus.winner_valid !== 1'b1 ||
            bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_first got lat1=%h done=%b win=%b/%b busy=%b exp 0037/10/1/1/1",
                     bus.lat[31:16], bus.done, bus.winner,
                     bus.winner_valid, bus.busy);
        end
        run_until(208, 2'b00);
        cyc(1'b0, 2'b01);
        checks++;
        if (bus.lat[15:0] !== 16'h0052 || bus.done !== 2'b11 ||
            bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_second got lat0=%h done=%b busy=%b exp 0052/11/0",
                     bus.lat[15:0], bus.done, bus.busy);
        end
        checks++;
        if (bus.best !== 16'h0037 || bus.best_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_best got %h/%b exp 0037/1",
                     bus.best, bus.best_valid);
        end
    endtask

    task automatic test_ignore();
        cyc(1'b0, 2'b11);
        cyc(1'b0, 2'b00);
        cyc(1'b0, 2'b10);
        checks++;
        if (bus.lat !== {16'h0037, 16'h0052} || bus.done !== 2'b11 ||
            bus.count !== to_bcd(m_count())) begin
            errors++;
            $display("FAIL done_stop got lat=%h done=%b count=%h exp 00370052/11/%h",
                     bus.lat, bus.done, bus.count, to_bcd(m_count()));
        end
        cyc(1'b0, 2'b01);
        cyc(1'b1, 2'b01);
        run_until(20, 2'b01);
        checks++;
        if (bus.done !== 2'b00 || bus.lat !== 32'h0) begin
            errors++;
            $display("FAIL held_stop got done=%b lat=%h exp 00/0",
                     bus.done, bus.lat);
        end
        run_until(200, 2'b00);
        cyc(1'b0, 2'b10);
        run_until(240, 2'b00);
        cyc(1'b0, 2'b01);
        checks++;
        if (bus.lat[31:16] !== 16'h0050 || bus.lat[15:0] !== 16'h0060 ||
            bus.best !== 16'h0037) begin
            errors++;
            $display("FAIL round2 got lat=%h best=%h exp 00500060/0037",
                     bus.lat, bus.best);
        end
        cyc(1'b1, 2'b00);
        run_until(48, 2'b00);
        cyc(1'b0, 2'b01);
        run_until(100, 2'b00);
        cyc(1'b0, 2'b10);
        checks++;
        if (bus.best !== 16'h0012 || bus.best_valid !== 1'b1 ||
            bus.winner !== 1'b0) begin
            errors++;
            $display("FAIL round3 got best=%h/%b win=%b exp 0012/1/0",
                     bus.best, bus.best_valid, bus.winner);
        end
    endtask

    task automatic test_simul();
        cyc(1'b1, 2'b00);
        run_until(83, 2'b00);
        cyc(1'b0, 2'b11);
        checks++;
        if (bus.lat !== {16'h0020, 16'h0020} || bus.winner !== 1'b0 ||
            bus.count !== 16'h0021) begin
            errors++;
            $display("FAIL simul got lat=%h win=%b count=%h exp 00200020/0/0021",
                     bus.lat, bus.winner, bus.count);
        end
        checks++;
        if (bus.best !== to_bcd(m_best) || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_best got %h busy=%b exp %h/0",
                     bus.best, bus.busy, to_bcd(m_best));
        end
    endtask

    task automatic test_timeout();
        int n1;
        int guard;
        bit bad;
        logic [1:0] sp;
        n1 = int'($urandom_range(400, 800));
        cyc(1'b1, 2'b00);
        guard = 0;
        while (m_run && guard < 41000) begin
            sp = (m_n == n1) ? 2'b10 : 2'b00;
            cyc(1'b0, sp);
            guard++;
            bad = 0;
            for (int d = 0; d < 4; d++)
                if (bus.count[d*4 +: 4] > 4'd9) bad = 1;
            checks++;
            if (bad || bus.count !== to_bcd(m_count())) begin
                errors++;
                $display("FAIL carry_count got %h exp %h at n=%0d",
                         bus.count, to_bcd(m_count()), m_n);
            end
        end
        checks++;
        if (m_run) begin
            errors++;
            $display("FAIL timeout_bound got running exp stopped");
        end
        checks++;
        if (bus.out_time !== 1'b1 || bus.count !== 16'h9999 ||
            bus.lat[15:0] !== 16'h9999 || bus.done !== 2'b11 ||
            bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout got out=%b count=%h lat0=%h done=%b busy=%b exp 1/9999/9999/11/0",
                     bus.out_time, bus.count, bus.lat[15:0],
                     bus.done, bus.busy);
        end
        checks++;
        if (bus.lat[31:16] !== to_bcd(n1 / TD) ||
            bus.best !== 16'h0012) begin
            errors++;
            $display("FAIL timeout_keep got lat1=%h best=%h exp %h/0012",
                     bus.lat[31:16], bus.best, to_bcd(n1 / TD));
        end
    endtask

    task automatic test_restart();
        cyc(1'b1, 2'b00);
        run_until(1600, 2'b00);
        checks++;
        if (bus.count !== 16'h0400) begin
            errors++;
            $display("FAIL restart_pre got %h exp 0400", bus.count);
        end
        cyc(1'b1, 2'b00);
        checks++;
        if (bus.count !== 16'h0000 || bus.done !== 2'b00 ||
            bus.out_time !== 1'b0 || bus.winner_valid !== 1'b0 ||
            bus.busy !== 1'b1 || bus.best !== 16'h0012) begin
            errors++;
            $display("FAIL restart got count=%h done=%b out=%b wv=%b busy=%b best=%h",
                     bus.count, bus.done, bus.out_time,
                     bus.winner_valid, bus.busy, bus.best);
        end
    endtask

    task automatic test_random();
        int t0, t1, guard;
        logic [1:0] sp;
        for (int r = 0; r < 6; r++) begin
            t0 = int'($urandom_range(1, 400));
            t1 = ($urandom_range(0, 3) == 0) ? t0
                 : int'($urandom_range(1, 400));
            cyc(1'b1, 2'b00);
            guard = 0;
            while (m_run && guard < 2000) begin
                sp[0] = (m_n >= t0 && m_n < t0 + 2);
                sp[1] = (m_n >= t1 && m_n < t1 + 2);
                cyc(1'b0, sp);
                guard++;
                checks++;
                if (bus.count !== to_bcd(m_count())) begin
                    errors++;
                    $display("FAIL rnd_count got %h exp %h",
                             bus.count, to_bcd(m_count()));
                end
            end
            checks++;
            if (bus.lat !== {to_bcd(m_lat[1]), to_bcd(m_lat[0])} ||
                bus.done !== m_done || bus.busy !== m_run ||
                bus.winner !== 1'(m_win) || bus.winner_valid !== m_wv) begin
                errors++;
                $display("FAIL rnd_round got lat=%h done=%b win=%b/%b exp lat=%h%h win=%0d",
                         bus.lat, bus.done, bus.winner, bus.winner_valid,
                         to_bcd(m_lat[1]), to_bcd(m_lat[0]), m_win);
            end
            checks++;
            if (bus.best !== to_bcd(m_best) || bus.best_valid !== m_bv) begin
                errors++;
                $display("FAIL rnd_best got %h exp %h",
                         bus.best, to_bcd(m_best));
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 2'b00;
        model_clear(0);
        test_reset();
        test_basic();
        test_ignore();
        test_simul();
        test_timeout();
        test_restart();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
